// File: rtl/memory_sequencer.sv
// Sequences 8/16-bit CPU accesses onto an 8-bit memory bus with a fixed read latency.
// Word accesses are little-endian: low byte at A, high byte at A+1 (wrapping at 0xFFFF).
module memory_sequencer #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] req_address,
  input  logic        req_write,
  input  logic        req_is_word,
  input  logic [15:0] req_data_in,
  output logic [15:0] req_data_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_enable,
  output logic        write_enable
);

  typedef enum logic [2:0] {
    IDLE,
    LO_ACCESS,
    LO_WAIT,
    HI_ACCESS,
    HI_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t     state_q;
  logic [1:0] cnt_q;
  logic       is_write_q;
  logic       is_word_q;
  logic [7:0] hi_data_q;
  logic [7:0] lo_byte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      is_write_q   <= 1'b0;
      is_word_q    <= 1'b0;
      hi_data_q    <= 8'h00;
      lo_byte_q    <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus_address  <= 16'h0000;
      bus_data_out <= 8'h00;
      bus_enable   <= 1'b0;
      write_enable <= 1'b0;
      req_data_out <= 16'h0000;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          bus_enable   <= 1'b0;
          write_enable <= 1'b0;
          state_q      <= IDLE;
          // Outputs are registered, so the low-byte bus phase is set up here.
          if (start) begin
            is_write_q   <= req_write;
            is_word_q    <= req_is_word;
            hi_data_q    <= req_data_in[15:8];
            bus_address  <= req_address;
            bus_data_out <= req_data_in[7:0];
            bus_enable   <= 1'b1;
            write_enable <= req_write;
            busy         <= 1'b1;
            state_q      <= LO_ACCESS;
          end
        end
        LO_ACCESS: begin
          if (is_write_q) begin
            if (is_word_q) begin
              bus_address  <= bus_address + 16'd1;
              bus_data_out <= hi_data_q;
              write_enable <= 1'b1;
              state_q      <= HI_ACCESS;
            end else begin
              write_enable <= 1'b0;
              bus_enable   <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state_q      <= DONE;
            end
          end else begin
            cnt_q   <= LAT;
            state_q <= LO_WAIT;
          end
        end
        LO_WAIT: begin
          if (cnt_q == 2'd1) begin
            cnt_q <= 2'd0;
            if (is_word_q) begin
              lo_byte_q   <= bus_data_in;
              bus_address <= bus_address + 16'd1;
              state_q     <= HI_ACCESS;
            end else begin
              req_data_out <= {8'h00, bus_data_in};
              bus_enable   <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state_q      <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        HI_ACCESS: begin
          if (is_write_q) begin
            write_enable <= 1'b0;
            bus_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q   <= LAT;
            state_q <= HI_WAIT;
          end
        end
        HI_WAIT: begin
          if (cnt_q == 2'd1) begin
            cnt_q        <= 2'd0;
            req_data_out <= {bus_data_in, lo_byte_q};
            bus_enable   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// Scoreboarded random + directed bench for memory_sequencer against a byte-array memory
// with a configurable read-latency pipeline.
module tb_memory_sequencer;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] req_address;
  logic        req_write;
  logic        req_is_word;
  logic [15:0] req_data_in;
  logic [15:0] req_data_out;
  logic        busy;
  logic        done;
  logic [15:0] bus_address;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic        bus_enable;
  logic        write_enable;

  memory_sequencer #(.READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .req_address(req_address),
    .req_write(req_write), .req_is_word(req_is_word), .req_data_in(req_data_in),
    .req_data_out(req_data_out), .busy(busy), .done(done), .bus_address(bus_address),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_enable(bus_enable),
    .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0100: return 8'h34;
      16'h0101: return 8'h12;
      16'hFFFF: return 8'hAA;
      16'h0000: return 8'h55;
      16'h8005: return 8'hC3;
      default:  return 8'(a * 37) ^ a[15:8];
    endcase
  endfunction

  // Bus-side memory: data for an address appears L cycles after it is presented.
  logic [7:0]  mem [65536];
  logic [15:0] apipe [L];
  bit          init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      init_done <= 1'b1;
    end else if (write_enable) begin
      mem[bus_address] <= bus_data_out;
    end
    apipe[0] <= bus_address;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign bus_data_in = mem[apipe[L-1]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard
  typedef struct {
    int          t0;
    int          lat;
    int          nwe;
    logic [15:0] data;
  } exp_t;
  exp_t        sbq[$];
  logic [7:0]  ref_mem [65536];
  logic [15:0] last_rd;
  int          total = 0;
  int          bad = 0;
  int          we_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_req(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    logic [15:0] a1;
    a1 = a + 16'd1;
    start = 1'b1; req_write = w; req_is_word = wd; req_address = a; req_data_in = d;
    e.t0 = cyc;
    if (w) begin
      e.lat = wd ? 3 : 2;
      e.nwe = wd ? 2 : 1;
      e.data = last_rd;
      ref_mem[a] = d[7:0];
      if (wd) ref_mem[a1] = d[15:8];
    end else begin
      e.lat = wd ? 3 + 2 * L : 2 + L;
      e.nwe = 0;
      e.data = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
      last_rd = e.data;
    end
    sbq.push_back(e);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 16'hFFF8 + 16'($urandom_range(0, 15));
      1: return 16'h3FF8 + 16'($urandom_range(0, 15));
      2: return 16'h0100 + 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic wait_free();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_free_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic issue(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d);
    wait_free();
    drive_req(w, wd, a, d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bus_enable"}, bus_enable, 0);
    check({tag, "_write_enable"}, write_enable, 0);
    check({tag, "_bus_address"}, bus_address, 0);
    check({tag, "_bus_data_out"}, bus_data_out, 0);
    check({tag, "_req_data_out"}, req_data_out, 0);
  endtask

  // Monitor: checks every completion against the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      we_cnt = 0;
    end else begin
      if (write_enable) begin
        we_cnt++;
        check("we_without_busy", busy, 1);
      end
      if (done) begin
        check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("done_latency", 32'(cyc - e.t0), 32'(e.lat));
          check("req_data_out", req_data_out, e.data);
          check("we_pulses", 32'(we_cnt), 32'(e.nwe));
        end
        check("busy_at_done", busy, 0);
        check("bus_idle_at_done", {bus_enable, write_enable}, 0);
        we_cnt = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    last_rd = 16'h0000;
    reset = 1'b1; start = 1'b1; req_write = 1'b1; req_is_word = 1'b1;
    req_address = 16'h1234; req_data_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Directed scenarios
    issue(1'b0, 1'b1, 16'h0100, 16'h0000);
    wait_idle();
    check("word_read_0100", req_data_out, 16'h1234);
    issue(1'b1, 1'b1, 16'h2000, 16'hBEEF);
    wait_idle();
    check("write_keeps_rdata", req_data_out, 16'h1234);
    issue(1'b0, 1'b1, 16'h2000, 16'h0000);
    wait_idle();
    check("readback_2000", req_data_out, 16'hBEEF);
    issue(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    wait_idle();
    check("wrap_read_ffff", req_data_out, 16'h55AA);

    // Byte read with start re-pulsed while busy
    wait_free();
    drive_req(1'b0, 1'b0, 16'h8005, 16'h0000);
    for (int k = 0; k < L + 1; k++) begin
      @(negedge clk);
      start = busy; req_address = 16'h0100; req_write = 1'b1; req_data_in = 16'h0BAD;
    end
    start = 1'b0;
    wait_idle();
    check("byte_read_8005", req_data_out, 16'h00C3);

    // Reset in cycle 2 of a word read
    wait_free();
    drive_req(1'b0, 1'b1, 16'h0100, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    last_rd = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("abort");
    issue(1'b0, 1'b0, 16'h0101, 16'h0000);
    wait_idle();
    check("after_abort", req_data_out, 16'h0012);

    // Random traffic, then back-to-back with start held high
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 300; n++) begin
        if (!busy && (phase == 1 || $urandom_range(0, 3) != 0)) begin
          drive_req(1'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
        end else begin
          start = (phase == 1) ? 1'b1 : (busy ? 1'($urandom) : 1'b0);
          req_address = rand_addr(); req_write = 1'($urandom);
          req_is_word = 1'($urandom); req_data_in = 16'($urandom);
        end
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
    end

    // Sweep read-back of the regions touched by random traffic
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [15:0] base;
        base = (r == 0) ? 16'hFFF8 : (r == 1) ? 16'h3FF8 : 16'h0100;
        issue(1'b0, 1'b1, base + 16'(i), 16'h0000);
      end
    end
    wait_idle();
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
